// File: rtl/isp_yuv422_packer_if.sv
// Pixel-in / packed-word-out bundle for the YUV422 packer.
// The slave modport is the packer; the master modport is the ISP/DMA side.
interface isp_yuv422_packer_if #(
  parameter int BITS = 8
);
  logic              in_href;
  logic              in_vsync;
  logic [BITS-1:0]   in_y;
  logic [BITS-1:0]   in_u;
  logic [BITS-1:0]   in_v;
  logic              out_valid;
  logic              out_ready;
  logic [4*BITS-1:0] out_data;
  logic              out_sof;
  logic              out_eol;

  modport master (
    output in_href, in_vsync, in_y, in_u, in_v, out_ready,
    input  out_valid, out_data, out_sof, out_eol
  );

  modport slave (
    input  in_href, in_vsync, in_y, in_u, in_v, out_ready,
    output out_valid, out_data, out_sof, out_eol
  );
endinterface

// File: rtl/isp_yuv422_packer.sv
// YUV444 -> YUYV packer: 2:1 chroma averaging, SOF/EOL tagging, show-ahead output FIFO.
//   state | meaning
//   IDLE  | between lines, waiting for href
//   LINE  | pairing pixels of an active line
//   FLUSH | one cycle after href falls; pushes the last word with eol=1
module isp_yuv422_packer #(
  parameter int BITS       = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_BITS   = 16
) (
  input  logic                            pclk,
  input  logic                            rst_n,
  isp_yuv422_packer_if.slave              vid,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
  output logic [CNT_BITS-1:0]             frame_cnt,
  output logic [CNT_BITS-1:0]             ovf_cnt
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int WW = 4 * BITS;

  typedef enum logic [1:0] {IDLE, LINE, FLUSH} state_t;

  state_t          state_q, state_d;
  logic            prev_href, prev_vsync;
  logic            phase_q, phase_d;
  logic            sof_pend;
  logic [BITS-1:0] y0_q, u0_q, v0_q;
  logic            latch;
  logic [WW-1:0]   stg_q, stg_d;
  logic            stg_vld_q, stg_vld_d;
  logic            push_req, push_eol, push_ok, pop;
  logic [WW-1:0]   push_word;
  logic [BITS:0]   u_sum, v_sum;
  logic [WW-1:0]   pair_word, pad_word;
  logic            vs_rise, hs_fall, pix_en;

  logic [WW+1:0]   mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [WW+1:0]   head;

  assign vs_rise = vid.in_vsync & ~prev_vsync;
  assign hs_fall = ~vid.in_href & prev_href;
  assign pix_en  = vid.in_href && (state_q != FLUSH);

  // BITS+1 sum so the +1 rounding term cannot overflow
  assign u_sum     = {1'b0, u0_q} + {1'b0, vid.in_u} + {{BITS{1'b0}}, 1'b1};
  assign v_sum     = {1'b0, v0_q} + {1'b0, vid.in_v} + {{BITS{1'b0}}, 1'b1};
  assign pair_word = {v_sum[BITS:1], vid.in_y, u_sum[BITS:1], y0_q};
  assign pad_word  = {v0_q, y0_q, u0_q, y0_q};

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    stg_d     = stg_q;
    stg_vld_d = stg_vld_q;
    push_req  = 1'b0;
    push_eol  = 1'b0;
    push_word = stg_q;
    latch     = 1'b0;
    if (vs_rise) begin
      state_d   = IDLE;
      phase_d   = 1'b0;
      stg_vld_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: if (vid.in_href) state_d = LINE;
        LINE: begin
          if (hs_fall) begin
            state_d = FLUSH;
            phase_d = 1'b0;
            if (phase_q) begin
              push_req  = stg_vld_q;
              stg_d     = pad_word;
              stg_vld_d = 1'b1;
            end
          end
        end
        FLUSH: begin
          state_d   = IDLE;
          push_req  = stg_vld_q;
          push_eol  = 1'b1;
          stg_vld_d = 1'b0;
        end
        default: state_d = IDLE;
      endcase
      if (pix_en) begin
        if (!phase_q) begin
          latch   = 1'b1;
          phase_d = 1'b1;
        end else begin
          phase_d   = 1'b0;
          stg_d     = pair_word;
          stg_vld_d = 1'b1;
          push_req  = stg_vld_q;
        end
      end
    end
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      prev_href  <= 1'b0;
      prev_vsync <= 1'b0;
      phase_q    <= 1'b0;
      stg_q      <= '0;
      stg_vld_q  <= 1'b0;
      y0_q       <= '0;
      u0_q       <= '0;
      v0_q       <= '0;
    end else begin
      state_q    <= state_d;
      prev_href  <= vid.in_href;
      prev_vsync <= vid.in_vsync;
      phase_q    <= phase_d;
      stg_q      <= stg_d;
      stg_vld_q  <= stg_vld_d;
      if (latch) begin
        y0_q <= vid.in_y;
        u0_q <= vid.in_u;
        v0_q <= vid.in_v;
      end
    end
  end

  // A full FIFO still accepts a push when the head is popped in the same cycle
  assign pop     = vid.out_valid & vid.out_ready;
  assign push_ok = push_req && ((fifo_level < ($clog2(FIFO_DEPTH)+1)'(FIFO_DEPTH)) || pop);

  always_ff @(posedge pclk) begin
    if (push_ok) mem[wr_ptr] <= {sof_pend, push_eol, push_word};
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      sof_pend   <= 1'b0;
      frame_cnt  <= '0;
      ovf_cnt    <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: fifo_level <= fifo_level;
      endcase
      if (vs_rise) begin
        sof_pend  <= 1'b1;
        frame_cnt <= frame_cnt + 1'b1;
      end else if (push_ok) begin
        sof_pend <= 1'b0;
      end
      if (push_req && !push_ok && (ovf_cnt != {CNT_BITS{1'b1}}))
        ovf_cnt <= ovf_cnt + 1'b1;
    end
  end

  assign head          = mem[rd_ptr];
  assign vid.out_valid = (fifo_level != '0);
  assign vid.out_data  = vid.out_valid ? head[WW-1:0] : '0;
  assign vid.out_eol   = vid.out_valid & head[WW];
  assign vid.out_sof   = vid.out_valid & head[WW+1];
endmodule
